// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: sequential word prefetch into a FWFT queue, redirect discards in-flight reads.
// Optional IF_PERF_CNT_EN adds perf_fetch / perf_drop event counters.
module if_prefetch_stage #(
  parameter int unsigned       ADDR_W   = 30,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       MAX_OUT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              pl_stall,
  input  logic              pl_flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_insn,
  output logic              if_en,
  output logic              busy
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch,
  output logic [31:0]       perf_drop
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(MAX_OUT + 1);

  logic [ADDR_W-1:0] fifo_pc   [DEPTH];
  logic [DATA_W-1:0] fifo_insn [DEPTH];
  logic [PW:0]       wr_ptr, rd_ptr, fifo_count;
  logic [OW-1:0]     outstanding, discard, outstanding_next;
  logic [ADDR_W-1:0] resp_pc, target;
  logic              empty, issue, redirect, accept_rsp, drop, pop;

  always_comb begin
    empty            = (wr_ptr == rd_ptr);
    fifo_count       = wr_ptr - rd_ptr;
    mem_req          = !rst && (32'(outstanding) < MAX_OUT) &&
                       ((32'(fifo_count) + 32'(outstanding)) < DEPTH);
    issue            = mem_req && mem_gnt;
    redirect         = pl_flush || br_taken;
    target           = pl_flush ? new_pc : br_addr;
    accept_rsp       = mem_rvalid && (discard == '0);
    drop             = mem_rvalid && (discard != '0);
    pop              = !empty && !pl_stall;
    outstanding_next = outstanding + OW'(issue) - OW'(mem_rvalid);
  end

  assign if_en   = !empty;
  assign busy    = empty;
  assign if_pc   = empty ? '0 : fifo_pc[rd_ptr[PW-1:0]];
  assign if_insn = empty ? '0 : fifo_insn[rd_ptr[PW-1:0]];

  // Response tags come from resp_pc rather than a per-request address queue:
  // responses are in order and every surviving one follows the last redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      discard     <= '0;
      mem_addr    <= RESET_PC;
      resp_pc     <= RESET_PC;
    end else begin
      outstanding <= outstanding_next;
      if (redirect) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        mem_addr <= target;
        resp_pc  <= target;
        discard  <= outstanding_next;
      end else begin
        if (issue)      mem_addr <= mem_addr + ADDR_W'(1);
        if (accept_rsp) begin
          wr_ptr  <= wr_ptr + (PW+1)'(1);
          resp_pc <= resp_pc + ADDR_W'(1);
        end
        if (pop)        rd_ptr  <= rd_ptr + (PW+1)'(1);
        if (drop)       discard <= discard - OW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !redirect && accept_rsp) begin
      fifo_pc[wr_ptr[PW-1:0]]   <= resp_pc;
      fifo_insn[wr_ptr[PW-1:0]] <= mem_rdata;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch <= '0;
      perf_drop  <= '0;
    end else begin
      if (issue) perf_fetch <= perf_fetch + 32'd1;
      if (drop)  perf_drop  <= perf_drop + 32'd1;
    end
  end
`endif

endmodule
